// File: rtl/mpc_fixed_pkg.sv
// Shared fixed-point definitions for the MPC QP ADMM datapath: word format, saturation
// bounds, FSM state type and the rescale/saturate helper.
package mpc_fixed_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned FRAC_BITS = 16;
  // Wide enough for a 2*DATA_W product summed over up to 256 columns.
  localparam int unsigned ACC_MAX_W = 2 * DATA_W + 8;

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  // Arithmetic shift right by FRAC_BITS (optionally round half up first), then clamp to DATA_W.
  function automatic logic [DATA_W-1:0] rescale_sat(input logic signed [ACC_MAX_W-1:0] acc,
                                                    input logic round_en);
    logic signed [ACC_MAX_W-1:0] half;
    logic signed [ACC_MAX_W-1:0] sh;
    logic signed [ACC_MAX_W-1:0] hi;
    logic signed [ACC_MAX_W-1:0] lo;
    half = '0;
    half[FRAC_BITS-1] = round_en;
    sh = (acc + half) >>> FRAC_BITS;
    hi = {{(ACC_MAX_W - DATA_W){1'b0}}, SAT_MAX};
    lo = {{(ACC_MAX_W - DATA_W){1'b1}}, SAT_MIN};
    if (sh > hi) begin
      return SAT_MAX;
    end else if (sh < lo) begin
      return SAT_MIN;
    end
    return sh[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mpc_mac_sat.sv
// Multiply-accumulate with per-row rescale and saturation. Rounding before the shift is
// enabled by defining MATVEC_ROUND_EN; otherwise the shift truncates toward -inf.
module mpc_mac_sat
  import mpc_fixed_pkg::*;
#(
  parameter int unsigned N_COLS = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] x,
  input  logic              prod_en,
  input  logic              acc_en,
  input  logic              acc_load,
  input  logic              out_en,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(N_COLS);

`ifdef MATVEC_ROUND_EN
  localparam logic RoundEn = 1'b1;
`else
  localparam logic RoundEn = 1'b0;
`endif

  logic signed [PROD_W-1:0]    prod_q;
  logic signed [PROD_W-1:0]    a_ext;
  logic signed [PROD_W-1:0]    x_ext;
  logic signed [ACC_W-1:0]     acc_q;
  logic signed [ACC_W-1:0]     prod_ext;
  logic signed [ACC_MAX_W-1:0] acc_wide;

  always_comb begin
    a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
    x_ext    = {{DATA_W{x[DATA_W-1]}}, x};
    prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    acc_wide = {{(ACC_MAX_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
      result <= '0;
    end else begin
      if (prod_en) begin
        prod_q <= a_ext * x_ext;
      end
      // First element of a row replaces the accumulator so rows need no separate clear.
      if (acc_en) begin
        acc_q <= acc_load ? prod_ext : acc_q + prod_ext;
      end
      if (out_en) begin
        result <= rescale_sat(acc_wide, RoundEn);
      end
    end
  end

endmodule

// File: rtl/mpc_qp_admm_matvec_sat.sv
// temp = sat(A * x) producer: streams one A/x element pair per cycle, writes one temp word per
// row. Optional round-half-up rescaling is selected with MATVEC_ROUND_EN (see mpc_mac_sat).
module mpc_qp_admm_matvec_sat
  import mpc_fixed_pkg::*;
#(
  parameter int unsigned N_ROWS = 24,
  parameter int unsigned N_COLS = 24
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst,
  input  logic                               ap_start,
  output logic                               ap_done,
  output logic                               ap_idle,
  output logic                               ap_ready,
  output logic [$clog2(N_ROWS*N_COLS)-1:0]   a_address0,
  output logic                               a_ce0,
  input  logic [DATA_W-1:0]                  a_q0,
  output logic [$clog2(N_COLS)-1:0]          x_address0,
  output logic                               x_ce0,
  input  logic [DATA_W-1:0]                  x_q0,
  output logic [$clog2(N_ROWS)-1:0]          temp_address0,
  output logic                               temp_ce0,
  output logic                               temp_we0,
  output logic [DATA_W-1:0]                  temp_d0
);

  localparam int unsigned RW = $clog2(N_ROWS);
  localparam int unsigned CW = $clog2(N_COLS);
  localparam int unsigned AW = $clog2(N_ROWS * N_COLS);

  state_e state_q, state_d;

  logic [RW-1:0] i_q;
  logic [CW-1:0] j_q;
  logic [AW-1:0] addr_q;
  logic          issue, row_first, row_last, pass_last;

  // Element tags travelling alongside the data: stage 1 = memory data, 2 = product, 3 = accumulator.
  logic          v1, first1, last1, fin1;
  logic          v2, first2, last2, fin2;
  logic          v3, last3, fin3;
  logic [RW-1:0] row1, row2, row3;
  logic          fin4;

  always_comb begin
    issue     = (state_q == StRun);
    row_first = (j_q == '0);
    row_last  = (j_q == CW'(N_COLS - 1));
    pass_last = row_last && (i_q == RW'(N_ROWS - 1));

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ap_start) state_d = StRun;
      StRun:   if (pass_last) state_d = StFlush;
      StFlush: if (temp_we0 && fin4) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && ap_start) begin
        i_q    <= '0;
        j_q    <= '0;
        addr_q <= '0;
      end else if (issue && !pass_last) begin
        addr_q <= addr_q + 1'b1;
        if (row_last) begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      {v1, first1, last1, fin1, row1} <= '0;
      {v2, first2, last2, fin2, row2} <= '0;
      {v3, last3, fin3, row3}         <= '0;
      temp_we0      <= 1'b0;
      temp_address0 <= '0;
      fin4          <= 1'b0;
    end else begin
      {v1, first1, last1, fin1, row1} <= {issue, row_first, row_last, pass_last, i_q};
      {v2, first2, last2, fin2, row2} <= {v1, first1, last1, fin1, row1};
      {v3, last3, fin3, row3}         <= {v2, last2, fin2, row2};
      temp_we0 <= v3 && last3;
      fin4     <= v3 && last3 && fin3;
      if (v3 && last3) begin
        temp_address0 <= row3;
      end
    end
  end

  mpc_mac_sat #(
    .N_COLS(N_COLS)
  ) u_mac (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .a        (a_q0),
    .x        (x_q0),
    .prod_en  (v1),
    .acc_en   (v2),
    .acc_load (first2),
    .out_en   (v3 && last3),
    .result   (temp_d0)
  );

  always_comb begin
    a_ce0      = issue;
    x_ce0      = issue;
    a_address0 = issue ? addr_q : '0;
    x_address0 = issue ? j_q : '0;
    temp_ce0   = temp_we0;
    ap_idle    = (state_q == StIdle) && !ap_start;
    ap_done    = (state_q == StDone);
    ap_ready   = (state_q == StDone);
  end

endmodule

// File: tb/tb_mpc_qp_admm_matvec_sat.sv
// Self-checking bench for mpc_qp_admm_matvec_sat: directed corner cases plus random matrices
// compared against a wide-integer reference; follows MATVEC_ROUND_EN like the design.
module tb_mpc_qp_admm_matvec_sat;

  localparam int NR = 24;
  localparam int NC = 24;
  localparam int LAT_DONE = NR * NC + 5;
  localparam int LAT_WR   = NR * NC + 4;

  logic        clk = 1'b0;
  logic        ap_rst, ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [9:0]  a_address0;
  logic        a_ce0, x_ce0;
  logic [31:0] a_q0, x_q0;
  logic [4:0]  x_address0, temp_address0;
  logic        temp_ce0, temp_we0;
  logic [31:0] temp_d0;

  logic [31:0] amem [NR*NC];
  logic [31:0] xmem [NC];
  logic [31:0] tmem [NR];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mpc_qp_admm_matvec_sat dut (
    .ap_clk        (clk),
    .ap_rst        (ap_rst),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .a_address0    (a_address0),
    .a_ce0         (a_ce0),
    .a_q0          (a_q0),
    .x_address0    (x_address0),
    .x_ce0         (x_ce0),
    .x_q0          (x_q0),
    .temp_address0 (temp_address0),
    .temp_ce0      (temp_ce0),
    .temp_we0      (temp_we0),
    .temp_d0       (temp_d0)
  );

  // Single-port memories with one cycle of read latency.
  always @(posedge clk) begin
    if (a_ce0) a_q0 <= amem[a_address0];
    if (x_ce0) x_q0 <= xmem[x_address0];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact dot product in 128-bit integers, then shift/round and clamp.
  function automatic logic [31:0] ref_row(input int i);
    logic signed [127:0] s;
    logic signed [127:0] p;
    s = 0;
    for (int j = 0; j < NC; j++) begin
      p = 128'($signed(amem[i*NC+j])) * 128'($signed(xmem[j]));
      s = s + p;
    end
`ifdef MATVEC_ROUND_EN
    s = s + 128'sd32768;
`endif
    s = s >>> 16;
    if (s > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -128'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < NR * NC; k++) amem[k] = '0;
    for (int k = 0; k < NC; k++) xmem[k] = '0;
  endtask

  // Runs from the cycle after the start-sampling edge; lat counts cycles since that edge.
  task automatic collect(input bit drop_start, output int done_lat, output int wr_cnt,
                         output int last_wr);
    done_lat = -1;
    wr_cnt   = 0;
    last_wr  = -1;
    for (int lat = 1; lat <= 2000; lat++) begin
      @(negedge clk);
      if (lat == 1 && drop_start) ap_start = 1'b0;
      if (temp_ce0 && temp_we0) begin
        tmem[temp_address0] = temp_d0;
        wr_cnt++;
        last_wr = lat;
      end
      if (ap_done) begin
        done_lat = lat;
        break;
      end
    end
  endtask

  task automatic check_rows(input string tag);
    for (int i = 0; i < NR; i++) check_val($sformatf("%s_row%0d", tag, i), tmem[i], ref_row(i));
  endtask

  task automatic run_pass(input string tag);
    int dl, wc, lw;
    for (int i = 0; i < NR; i++) tmem[i] = 32'hDEAD_BEEF;
    @(negedge clk);
    ap_start = 1'b1;
    @(posedge clk);
    collect(1'b1, dl, wc, lw);
    check_val({tag, "_done_lat"}, dl, LAT_DONE);
    check_val({tag, "_ready"}, ap_ready, 1);
    check_val({tag, "_writes"}, wc, NR);
    check_val({tag, "_last_wr"}, lw, LAT_WR);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, ap_done, 0);
    check_val({tag, "_idle_after"}, ap_idle, 1);
    check_rows(tag);
  endtask

  function automatic logic [31:0] rand_word(input int mode);
    logic [31:0] w;
    w = $urandom;
    case (mode)
      0: rand_word = w;
      1: rand_word = 32'($signed(w) >>> 12);
      default: rand_word = ($urandom_range(0, 3) == 0) ? w : 32'($signed(w) >>> 14);
    endcase
  endfunction

  initial begin
    int dl1, dl2, wc, lw, wr_rst;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_a_ce", a_ce0, 0);
    check_val("rst_x_ce", x_ce0, 0);
    check_val("rst_temp_ce", temp_ce0, 0);
    check_val("rst_temp_we", temp_we0, 0);
    check_val("rst_done", ap_done, 0);
    check_val("rst_ready", ap_ready, 0);
    check_val("rst_idle", ap_idle, 1);
    check_val("rst_a_addr", a_address0, 0);
    check_val("rst_temp_d", temp_d0, 0);
    ap_rst = 1'b0;

    // Identity times ramp.
    for (int i = 0; i < NR; i++) amem[i*NC+i] = 32'h0001_0000;
    for (int j = 0; j < NC; j++) xmem[j] = j << 16;
    run_pass("ident");
    for (int i = 0; i < NR; i++) check_val($sformatf("ident_const%0d", i), tmem[i], i << 16);

    // Saturation both ways.
    clear_mem();
    for (int j = 0; j < NC; j++) begin
      amem[j] = 32'h7FFF_FFFF;
      xmem[j] = 32'h7FFF_FFFF;
    end
    run_pass("satpos");
    check_val("satpos_const", tmem[0], 32'h7FFF_FFFF);
    for (int j = 0; j < NC; j++) xmem[j] = 32'h8000_0001;
    run_pass("satneg");
    check_val("satneg_const", tmem[0], 32'h8000_0000);

    // Half-LSB rounding boundary.
    clear_mem();
    amem[0] = 32'h0000_0001;
    xmem[0] = 32'h0000_8000;
    run_pass("half");
`ifdef MATVEC_ROUND_EN
    check_val("half_const", tmem[0], 32'h0000_0001);
`else
    check_val("half_const", tmem[0], 32'h0000_0000);
`endif

    // Negative operands.
    amem[0] = 32'hFFFF_0000;
    xmem[0] = 32'h0001_8000;
    run_pass("neg15");
    check_val("neg15_const", tmem[0], 32'hFFFE_8000);
    amem[0] = 32'hFFFF_FFFF;
    xmem[0] = 32'h0000_8000;
    run_pass("neglsb");
`ifdef MATVEC_ROUND_EN
    check_val("neglsb_const", tmem[0], 32'h0000_0000);
`else
    check_val("neglsb_const", tmem[0], 32'hFFFF_FFFF);
`endif

    // Random matrices across magnitude ranges.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < NR * NC; k++) amem[k] = rand_word(t % 3);
      for (int k = 0; k < NC; k++) xmem[k] = rand_word(t % 3);
      run_pass($sformatf("rand%0d", t));
    end

    // Reset in the middle of a pass.
    @(negedge clk);
    ap_start = 1'b1;
    @(posedge clk);
    for (int lat = 1; lat < 100; lat++) begin
      @(negedge clk);
      ap_start = 1'b0;
    end
    @(negedge clk);
    ap_rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_a_ce", a_ce0, 0);
    check_val("mid_rst_x_ce", x_ce0, 0);
    check_val("mid_rst_temp_we", temp_we0, 0);
    check_val("mid_rst_idle", ap_idle, 1);
    wr_rst = 0;
    repeat (4) begin
      @(negedge clk);
      if (temp_we0) wr_rst++;
    end
    ap_rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (temp_we0) wr_rst++;
    end
    check_val("mid_rst_no_writes", wr_rst, 0);
    run_pass("after_rst");

    // Back-to-back passes with start held; A changes between passes.
    for (int i = 0; i < NR; i++) tmem[i] = 32'hDEAD_BEEF;
    @(negedge clk);
    ap_start = 1'b1;
    @(posedge clk);
    collect(1'b0, dl1, wc, lw);
    check_val("b2b_done1", dl1, LAT_DONE);
    check_rows("b2b_p1");
    for (int k = 0; k < NR * NC; k++) amem[k] = rand_word(1);
    // The second pass's count starts in the IDLE cycle that resamples start.
    collect(1'b0, dl2, wc, lw);
    ap_start = 1'b0;
    check_val("b2b_gap", dl2, LAT_DONE + 1);
    check_val("b2b_writes2", wc, NR);
    check_rows("b2b_p2");
    @(negedge clk);
    check_val("b2b_done_pulse", ap_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
